// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter (with bounded lock) in front of a single-port,
// byte-writable data memory; out-of-range requests are answered with an error.
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE = 256,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core,
  input  logic [1:0]  Req_Valid,
  input  logic [1:0]  Req_Lock,
  input  logic [1:0]  Req_Read,
  input  logic [63:0] Req_Addr,
  input  logic [63:0] Req_Wdata,
  input  logic [7:0]  Req_Wstrb,
  output logic [1:0]  Req_Gnt,
  output logic [1:0]  Rsp_Valid,
  output logic        Rsp_Err,
  output logic [31:0] Rsp_Rdata,
  output logic        Read_Ctrl,
  output logic [3:0]  Write_Ctrl,
  output logic [31:0] Mem_Data_Address,
  output logic [31:0] Mem_Data_Write,
  input  logic [31:0] Mem_Data_Read
);

  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_SIZE) << 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic             rr_last_q, rr_last_d;
  logic             lock_act_q, lock_act_d;
  logic             lock_port_q, lock_port_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_is_read_q, rsp_is_read_d;

  logic             lock_hit, gnt_any, gnt_port, in_range, mem_go, keep_lock;
  logic             sel_read, sel_lock;
  logic [31:0]      sel_addr, sel_wdata;
  logic [3:0]       sel_wstrb;
  logic [CNT_W-1:0] base_cnt;

  // Arbitration: live lock owner first, then round-robin, then the lone requester
  always_comb begin
    gnt_any  = 1'b0;
    gnt_port = 1'b0;
    lock_hit = lock_act_q && Req_Valid[lock_port_q];
    if (!Rst_Core) begin
      if (lock_hit) begin
        gnt_any  = 1'b1;
        gnt_port = lock_port_q;
      end else if (&Req_Valid) begin
        gnt_any  = 1'b1;
        gnt_port = ~rr_last_q;
      end else if (Req_Valid[0]) begin
        gnt_any  = 1'b1;
        gnt_port = 1'b0;
      end else if (Req_Valid[1]) begin
        gnt_any  = 1'b1;
        gnt_port = 1'b1;
      end
    end
  end

  assign sel_addr  = gnt_port ? Req_Addr[63:32]  : Req_Addr[31:0];
  assign sel_wdata = gnt_port ? Req_Wdata[63:32] : Req_Wdata[31:0];
  assign sel_wstrb = gnt_port ? Req_Wstrb[7:4]   : Req_Wstrb[3:0];
  assign sel_read  = Req_Read[gnt_port];
  assign sel_lock  = Req_Lock[gnt_port];
  assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;
  assign mem_go    = gnt_any && in_range;

  assign Req_Gnt          = gnt_any ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;
  assign Read_Ctrl        = mem_go && sel_read;
  assign Write_Ctrl       = (mem_go && !sel_read) ? sel_wstrb : 4'h0;
  assign Mem_Data_Address = mem_go ? sel_addr : 32'h0;
  assign Mem_Data_Write   = (mem_go && !sel_read) ? sel_wdata : 32'h0;

  // A grant to a port that was not the live lock owner starts a fresh lock run
  always_comb begin
    base_cnt      = lock_hit ? lock_cnt_q : '0;
    keep_lock     = gnt_any && sel_lock && (base_cnt < CNT_LAST);
    lock_act_d    = keep_lock;
    lock_port_d   = keep_lock ? gnt_port : 1'b0;
    lock_cnt_d    = keep_lock ? base_cnt + CNT_W'(1) : '0;
    rr_last_d     = gnt_any ? gnt_port : rr_last_q;
    rsp_valid_d   = Req_Gnt;
    rsp_err_d     = gnt_any && !in_range;
    rsp_is_read_d = mem_go && sel_read;
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      rr_last_q     <= 1'b1;
      lock_act_q    <= 1'b0;
      lock_port_q   <= 1'b0;
      lock_cnt_q    <= '0;
      rsp_valid_q   <= 2'b00;
      rsp_err_q     <= 1'b0;
      rsp_is_read_q <= 1'b0;
    end else begin
      rr_last_q     <= rr_last_d;
      lock_act_q    <= lock_act_d;
      lock_port_q   <= lock_port_d;
      lock_cnt_q    <= lock_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_is_read_q <= rsp_is_read_d;
    end
  end

  // Memory read data is only meaningful in the cycle after an in-range load
  assign Rsp_Valid = rsp_valid_q;
  assign Rsp_Err   = rsp_err_q;
  assign Rsp_Rdata = rsp_is_read_q ? Mem_Data_Read : 32'h0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port byte-writable data memory between two requesters: port 0 is the core load/store path and port 1 is the debug/DMA loader. It grants round-robin, with an optional bounded lock for back-to-back bursts. It drives the memory's read/write-strobe/address/data inputs and routes the one-cycle-latency read data back to the port that issued the read. Out-of-range addresses get an error response and never reach the memory.

Parameters:
MEM_SIZE, 256, memory depth in 32-bit words; valid byte addresses are 0 to MEM_SIZE*4-1
LOCK_MAX, 8, maximum consecutive grants to one port while its lock bit is held (>=1)

Ports:
Clk_Core  in  1  core clock; all state updates on posedge
Rst_Core  in  1  synchronous active-high reset
Req_Valid  in  2  bit p: port p has a request pending
Req_Lock  in  2  bit p: port p requests it keep the grant after the current beat
Req_Read  in  2  bit p: 1=load, 0=store
Req_Addr  in  64  port p byte address at [32p+31:32p]
Req_Wdata  in  64  port p store data at [32p+31:32p]
Req_Wstrb  in  8  port p byte strobes at [4p+3:4p]
Req_Gnt  out  2  one-hot, combinational: port p request accepted this cycle
Rsp_Valid  out  2  registered: response for port p's previous accepted request
Rsp_Err  out  1  registered: current response is an out-of-range error
Rsp_Rdata  out  32  load data, valid when Rsp_Valid!=0 and the response is for a load
Read_Ctrl  out  1  to memory read enable
Write_Ctrl  out  4  to memory byte write strobes
Mem_Data_Address  out  32  to memory byte address
Mem_Data_Write  out  32  to memory write data
Mem_Data_Read  in  32  from memory, registered read data (1-cycle latency)

Behaviour:
- Reset: rr_last=1, so port 0 wins first; lock_owner=none; lock_cnt=0; Rsp_Valid=0; Rsp_Err=0; Rsp_Rdata=0; rsp_is_read=0. Combinational outputs are 0 when nothing is granted.
- Handshake: the requester holds Valid, Read, Addr, Wdata and Wstrb stable until Gnt is high. A request is accepted in the cycle where Valid&Gnt. At most one grant per cycle. Throughput is 1 request/cycle.
- Arbitration:
  - If lock_owner=p and Req_Valid[p], grant p.
  - Otherwise, if both ports are valid, grant the port != rr_last.
  - Otherwise, grant the only valid port.
  - On each grant, rr_last is set to the granted port.
- Lock:
  - On a grant to p with Req_Lock[p]=1 and lock_cnt<LOCK_MAX-1: lock_owner=p and lock_cnt++.
  - Otherwise: lock_owner=none and lock_cnt=0.
  - If the owner drops Valid, the lock is released in that same cycle and the other port may be granted.
  - When LOCK_MAX is reached, the lock is forcibly released, so the other port, if valid, wins the next cycle.
- Range check: in_range = Addr < MEM_SIZE*4, computed with 33-bit unsigned arithmetic so there is no wrap.
- Memory drive in the grant cycle, in range only:
  - Load: Read_Ctrl=1, Write_Ctrl=0.
  - Store: Read_Ctrl=0, Write_Ctrl=Wstrb.
  - Address and data are passed unmodified; the low 2 address bits are ignored by the memory.
- Out of range: nothing is driven to the memory (Read_Ctrl=0, Write_Ctrl=0, address=0).
- Response timing: one cycle after a grant, Rsp_Valid = onehot(granted port). Rsp_Err = !in_range registered.
- Response data: Rsp_Rdata = Mem_Data_Read for an in-range load. For an error or a store it is 32'h0. Never sample Mem_Data_Read outside a load response; it is high-Z otherwise.
- Store with Wstrb=0 is still granted and acknowledged, with no memory effect.
- Reset asserted mid-transaction: any pending response is dropped, the arbiter returns to the reset state, and Gnt=0 in the reset cycle.

Test Plan:
- Store then load, both on port 0: store Addr=0x10, Wdata=0xDEADBEEF, Wstrb=F; next cycle load Addr=0x10 -> Rsp_Valid=01 with Rsp_Rdata=0xDEADBEEF one cycle after the load grant.
- Byte store: port 1 stores Wstrb=0100, Wdata=0x00AB0000 to 0x10 (holding 0xDEADBEEF) -> a later port 0 load returns 0xDEABBEEF.
- Contention: both ports valid continuously with no lock -> grants alternate 01,10,01,10; each Rsp_Valid bit follows its grant by exactly 1 cycle.
- Lock, LOCK_MAX=8: port 1 holds Valid+Lock and port 0 is valid -> port 1 gets 8 consecutive grants, then port 0 is granted on the 9th cycle.
- Out of range: MEM_SIZE=256, load Addr=0x400 -> no Read_Ctrl pulse, Rsp_Err=1, Rsp_Rdata=0. Store to 0xFFFFFFFC -> Write_Ctrl stays 0 and the next load to 0x3FC is unchanged.
- Reset mid-stream: assert Rst_Core in a grant cycle -> the next cycle has Rsp_Valid=0, and port 0 wins the first contention after reset.
